// File: rtl/cdec_dp_gen.sv
// CDEC data path: XBUS register file, ALU, flags, req/ack memory port with
// timeout, and a combinational debug resource port.
module cdec_dp_gen #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  parameter int SELW  = 4,
  parameter int TMO   = 15
) (
  input  logic             clock,
  input  logic             reset_N,
  input  logic [SELW-1:0]  xsrc,
  input  logic [SELW-1:0]  xdst,
  input  logic [3:0]       alu_op,
  input  logic             rwr,
  input  logic             fwr,
  input  logic             pc_inc,
  input  logic             mem_rd,
  input  logic             mem_wr,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  output logic [WIDTH-1:0] adrs,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic [WIDTH-1:0] I,
  output logic [2:0]       SZCy,
  input  logic [7:0]       resad,
  output logic [WIDTH-1:0] resdt
);

  // state | meaning
  // IDLE  | no transaction; accepts mem_rd / mem_wr
  // RD    | read request outstanding; RDR loads on the ack edge
  // WR    | write request outstanding
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] pc, ir, t_reg, r_reg, mar, wdr, rdr;
  logic [3:0]       flg;  // {E, S, Z, Cy}
  logic [WIDTH-1:0] g [NREG];
  logic [7:0]       tmo_cnt;

  logic [WIDTH-1:0] flg_word, xbus, alu_res;
  logic             alu_cy, tmo_hit, err_set;

  always_comb begin
    flg_word      = '0;
    flg_word[4:1] = flg;
  end

  always_comb begin
    xbus = '1;
    case (xsrc)
      SELW'(0): xbus = pc;
      SELW'(1): xbus = r_reg;
      SELW'(2): xbus = rdr;
      SELW'(3): xbus = flg_word;
      default: begin
        for (int k = 0; k < NREG; k++)
          if (xsrc == SELW'(4 + k)) xbus = g[k];
      end
    endcase
  end

  // Arithmetic ops use a WIDTH+1 result so the top bit is carry or borrow.
  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    case (alu_op)
      4'h0: alu_res = xbus;
      4'h1: {alu_cy, alu_res} = {1'b0, xbus} + {1'b0, t_reg};
      4'h2: {alu_cy, alu_res} = {1'b0, xbus} + {1'b0, t_reg} + {{WIDTH{1'b0}}, flg[0]};
      4'h3: {alu_cy, alu_res} = {1'b0, xbus} - {1'b0, t_reg};
      4'h4: {alu_cy, alu_res} = {1'b0, xbus} - {1'b0, t_reg} - {{WIDTH{1'b0}}, flg[0]};
      4'h5: alu_res = xbus & t_reg;
      4'h6: alu_res = xbus | t_reg;
      4'h7: alu_res = xbus ^ t_reg;
      4'h8: alu_res = ~xbus;
      4'h9: begin
        alu_res = {xbus[WIDTH-2:0], 1'b0};
        alu_cy  = xbus[WIDTH-1];
      end
      4'hA: begin
        alu_res = {1'b0, xbus[WIDTH-1:1]};
        alu_cy  = xbus[0];
      end
      4'hB: begin
        alu_res = {xbus[WIDTH-2:0], xbus[WIDTH-1]};
        alu_cy  = xbus[WIDTH-1];
      end
      4'hC: begin
        alu_res = {xbus[0], xbus[WIDTH-1:1]};
        alu_cy  = xbus[0];
      end
      4'hD: {alu_cy, alu_res} = {1'b0, xbus} + (WIDTH+1)'(1);
      4'hE: {alu_cy, alu_res} = {1'b0, xbus} - (WIDTH+1)'(1);
      4'hF: alu_res = t_reg;
    endcase
  end

  assign tmo_hit = (state != IDLE) && !mem_ack && (tmo_cnt == 8'(TMO - 1));
  assign err_set = (state == IDLE) ? (mem_rd & mem_wr) : ((mem_rd | mem_wr) | tmo_hit);

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      pc    <= '0;
      ir    <= '0;
      t_reg <= '0;
      r_reg <= '0;
      mar   <= '0;
      wdr   <= '0;
      flg   <= '0;
      for (int k = 0; k < NREG; k++) g[k] <= '0;
    end else begin
      if (xdst == SELW'(1)) pc <= xbus;
      else if (pc_inc) pc <= pc + WIDTH'(1);
      if (xdst == SELW'(2)) ir <= xbus;
      if (xdst == SELW'(3)) t_reg <= xbus;
      if (xdst == SELW'(4)) mar <= xbus;
      if (xdst == SELW'(5)) wdr <= xbus;
      for (int k = 0; k < NREG; k++)
        if (xdst == SELW'(8 + k)) g[k] <= xbus;
      if (rwr) r_reg <= alu_res;
      if (fwr) flg[2:0] <= {alu_res[WIDTH-1], alu_res == '0, alu_cy};
      // An error raised by the memory FSM wins over an fwr clear.
      if (err_set) flg[3] <= 1'b1;
      else if (fwr) flg[3] <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
      tmo_cnt <= '0;
      rdr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_rd ^ mem_wr) begin
            state   <= mem_rd ? RD : WR;
            mem_req <= 1'b1;
            mem_we  <= mem_wr;
            busy    <= 1'b1;
            tmo_cnt <= '0;
          end
        end
        RD, WR: begin
          if (mem_ack) begin
            if (state == RD) rdr <= data_in;
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
          end else if (tmo_hit) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    resdt = '0;
    case (resad)
      8'h00: resdt = pc;
      8'h01: resdt = ir;
      8'h02: resdt = t_reg;
      8'h03: resdt = r_reg;
      8'h04: resdt = mar;
      8'h05: resdt = data_in;
      8'h06: resdt = rdr;
      8'h07: resdt = wdr;
      8'h0D: resdt = flg_word;
      8'h0E: resdt = WIDTH'(state);
      default: begin
        for (int k = 0; k < NREG; k++)
          if (resad == 8'(16 + k)) resdt = g[k];
      end
    endcase
  end

  assign adrs     = mar;
  assign data_out = wdr;
  assign I        = ir;
  assign SZCy     = flg[2:0];

endmodule

// File: tb/tb_cdec_dp_gen.sv
// Testbench for cdec_dp_gen: directed vector table, multi-cycle memory and
// reset sequences, and a randomized run against a behavioural model.
module tb_cdec_dp_gen;
  localparam int W = 8, NREG = 4, SELW = 4, TMO = 15;

  logic            clock = 1'b0;
  logic            reset_N;
  logic [SELW-1:0] xsrc, xdst;
  logic [3:0]      alu_op;
  logic            rwr, fwr, pc_inc, mem_rd, mem_wr, mem_ack;
  logic            mem_req, mem_we, busy;
  logic [W-1:0]    adrs, data_in, data_out, I, resdt;
  logic [2:0]      SZCy;
  logic [7:0]      resad;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    logic [3:0] xsrc, xdst, op;
    logic       rwr, fwr, pci, rd, wr, ack;
    logic [7:0] din;
  } in_t;

  typedef struct {
    in_t        in;
    logic [7:0] ra;
    int         edt;
    int         esz;
  } vec_t;

  // model state
  int m_pc, m_i, m_t, m_r, m_mar, m_wdr, m_rdr;
  int m_e, m_s, m_z, m_c, m_st, m_waited;
  int m_g[NREG];

  cdec_dp_gen #(.WIDTH(W), .NREG(NREG), .SELW(SELW), .TMO(TMO)) dut (
    .clock(clock), .reset_N(reset_N), .xsrc(xsrc), .xdst(xdst), .alu_op(alu_op),
    .rwr(rwr), .fwr(fwr), .pc_inc(pc_inc), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .adrs(adrs),
    .data_in(data_in), .data_out(data_out), .busy(busy), .I(I), .SZCy(SZCy),
    .resad(resad), .resdt(resdt)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    m_pc = 0; m_i = 0; m_t = 0; m_r = 0; m_mar = 0; m_wdr = 0; m_rdr = 0;
    m_e = 0; m_s = 0; m_z = 0; m_c = 0; m_st = 0; m_waited = 0;
    for (int k = 0; k < NREG; k++) m_g[k] = 0;
  endtask

  function automatic int m_flg();
    return m_e * 16 + m_s * 8 + m_z * 4 + m_c * 2;
  endfunction

  function automatic int m_src(int s);
    if (s == 0) return m_pc;
    if (s == 1) return m_r;
    if (s == 2) return m_rdr;
    if (s == 3) return m_flg();
    if (s >= 4 && s < 4 + NREG) return m_g[s - 4];
    return 255;
  endfunction

  function automatic int m_res(int a);
    case (a)
      'h00: return m_pc;
      'h01: return m_i;
      'h02: return m_t;
      'h03: return m_r;
      'h04: return m_mar;
      'h05: return int'(data_in);
      'h06: return m_rdr;
      'h07: return m_wdr;
      'h0D: return m_flg();
      'h0E: return m_st;
      default: begin
        if (a >= 16 && a < 16 + NREG) return m_g[a - 16];
        return 0;
      end
    endcase
  endfunction

  task automatic alu_model(input int op, input int x, input int t, input int ci,
                           output int res, output int cy);
    int s;
    cy = 0;
    case (op)
      0:  res = x;
      1:  begin s = x + t;      res = s % 256; cy = (s > 255) ? 1 : 0; end
      2:  begin s = x + t + ci; res = s % 256; cy = (s > 255) ? 1 : 0; end
      3:  begin s = x - t;      res = (s + 512) % 256; cy = (s < 0) ? 1 : 0; end
      4:  begin s = x - t - ci; res = (s + 512) % 256; cy = (s < 0) ? 1 : 0; end
      5:  res = x & t;
      6:  res = x | t;
      7:  res = x ^ t;
      8:  res = 255 - x;
      9:  begin res = (x * 2) % 256; cy = x / 128; end
      10: begin res = x / 2; cy = x % 2; end
      11: begin res = (x * 2) % 256 + x / 128; cy = x / 128; end
      12: begin res = x / 2 + (x % 2) * 128; cy = x % 2; end
      13: begin s = x + 1; res = s % 256; cy = (s > 255) ? 1 : 0; end
      14: begin res = (x + 255) % 256; cy = (x == 0) ? 1 : 0; end
      default: res = t;
    endcase
  endtask

  task automatic model_next(input in_t v);
    int x, res, cy, e_set, dst;
    x = m_src(int'(v.xsrc));
    alu_model(int'(v.op), x, m_t, m_c, res, cy);
    e_set = 0;
    if (m_st == 0) begin
      if (v.rd && v.wr) e_set = 1;
      else if (v.rd) begin m_st = 1; m_waited = 0; end
      else if (v.wr) begin m_st = 2; m_waited = 0; end
    end else begin
      if (v.rd || v.wr) e_set = 1;
      if (v.ack) begin
        if (m_st == 1) m_rdr = int'(v.din);
        m_st = 0;
      end else begin
        m_waited++;
        if (m_waited >= TMO) begin m_st = 0; e_set = 1; end
      end
    end
    dst = int'(v.xdst);
    if (dst == 1) m_pc = x;
    else if (v.pci) m_pc = (m_pc + 1) % 256;
    if (dst == 2) m_i = x;
    if (dst == 3) m_t = x;
    if (dst == 4) m_mar = x;
    if (dst == 5) m_wdr = x;
    if (dst >= 8 && dst < 8 + NREG) m_g[dst - 8] = x;
    if (v.rwr) m_r = res;
    if (v.fwr) begin
      m_s = res / 128; m_z = (res == 0) ? 1 : 0; m_c = cy; m_e = 0;
    end
    if (e_set != 0) m_e = 1;
  endtask

  task automatic check_state(input int ra);
    resad = 8'(ra);
    #1;
    chk("busy", int'(busy), (m_st != 0) ? 1 : 0);
    chk("mem_req", int'(mem_req), (m_st != 0) ? 1 : 0);
    chk("mem_we", int'(mem_we), (m_st == 2) ? 1 : 0);
    chk("adrs", int'(adrs), m_mar);
    chk("data_out", int'(data_out), m_wdr);
    chk("I", int'(I), m_i);
    chk("SZCy", int'(SZCy), m_s * 4 + m_z * 2 + m_c);
    chk($sformatf("resdt[%02h]", ra), int'(resdt), m_res(ra));
  endtask

  task automatic step(input in_t v, input int ra);
    xsrc = v.xsrc; xdst = v.xdst; alu_op = v.op; rwr = v.rwr; fwr = v.fwr;
    pc_inc = v.pci; mem_rd = v.rd; mem_wr = v.wr; mem_ack = v.ack; data_in = v.din;
    model_next(v);
    @(posedge clock);
    #1;
    check_state(ra);
  endtask

  function automatic in_t nop();
    in_t v;
    v.xsrc = '0; v.xdst = '0; v.op = '0; v.rwr = 1'b0; v.fwr = 1'b0;
    v.pci = 1'b0; v.rd = 1'b0; v.wr = 1'b0; v.ack = 1'b0; v.din = '0;
    return v;
  endfunction

  function automatic in_t op_in(int src, int dst, int op, int rw);
    in_t v;
    v = nop();
    v.xsrc = 4'(src); v.xdst = 4'(dst); v.op = 4'(op); v.rwr = 1'(rw);
    return v;
  endfunction

  function automatic vec_t mk(int src, int dst, int op, int rw, int fw, int pci,
                              int ra, int edt, int esz);
    vec_t e;
    e.in = op_in(src, dst, op, rw);
    e.in.fwr = 1'(fw);
    e.in.pci = 1'(pci);
    e.ra = 8'(ra); e.edt = edt; e.esz = esz;
    return e;
  endfunction

  initial begin
    vec_t tbl[$];
    in_t  v;
    int   cnt;

    reset_N = 1'b0;
    xsrc = '0; xdst = '0; alu_op = '0; rwr = 0; fwr = 0; pc_inc = 0;
    mem_rd = 0; mem_wr = 0; mem_ack = 0; data_in = '0; resad = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset_N = 1'b1;

    for (int a = 0; a < 32; a++) begin
      resad = 8'(a);
      #1;
      chk($sformatf("reset_resdt[%02h]", a), int'(resdt), 0);
    end
    chk("reset_busy", int'(busy), 0);
    chk("reset_mem_req", int'(mem_req), 0);

    //        src dst op rw fw pci  ra    edt   szcy
    tbl.push_back(mk(15, 3, 0, 0, 0, 0, 'h02, 'hFF, 0));
    tbl.push_back(mk(15, 0, 9, 1, 0, 0, 'h03, 'hFE, 0));
    tbl.push_back(mk(1,  0, 9, 1, 0, 0, 'h03, 'hFC, 0));
    tbl.push_back(mk(1,  0, 9, 1, 0, 0, 'h03, 'hF8, 0));
    tbl.push_back(mk(1,  0, 9, 1, 0, 0, 'h03, 'hF0, 0));
    tbl.push_back(mk(1,  8, 0, 0, 0, 0, 'h10, 'hF0, 0));
    tbl.push_back(mk(0,  0, 13, 1, 0, 0, 'h03, 'h01, 0));
    tbl.push_back(mk(1,  0, 9, 1, 0, 0, 'h03, 'h02, 0));
    tbl.push_back(mk(1,  0, 9, 1, 0, 0, 'h03, 'h04, 0));
    tbl.push_back(mk(1,  0, 9, 1, 0, 0, 'h03, 'h08, 0));
    tbl.push_back(mk(1,  0, 9, 1, 0, 0, 'h03, 'h10, 0));
    tbl.push_back(mk(1,  0, 9, 1, 0, 0, 'h03, 'h20, 0));
    tbl.push_back(mk(1,  3, 13, 1, 0, 0, 'h02, 'h20, 0));
    tbl.push_back(mk(1,  0, 9, 1, 0, 0, 'h03, 'h42, 0));
    tbl.push_back(mk(1,  9, 0, 0, 0, 0, 'h11, 'h42, 0));
    tbl.push_back(mk(4,  0, 1, 1, 1, 0, 'h03, 'h10, 1));
    tbl.push_back(mk(4,  0, 13, 1, 0, 0, 'h03, 'hF1, 1));
    tbl.push_back(mk(1,  3, 0, 0, 0, 0, 'h02, 'hF1, 1));
    tbl.push_back(mk(4,  0, 3, 1, 1, 0, 'h03, 'hFF, 5));
    tbl.push_back(mk(15, 1, 0, 0, 0, 0, 'h00, 'hFF, 5));
    tbl.push_back(mk(0,  0, 0, 0, 0, 1, 'h00, 'h00, 5));
    tbl.push_back(mk(5,  1, 0, 0, 0, 1, 'h00, 'h42, 5));
    tbl.push_back(mk(3,  4, 0, 0, 0, 0, 'h04, 'h0A, 5));
    tbl.push_back(mk(2,  5, 0, 0, 0, 0, 'h0D, 'h0A, 5));
    tbl.push_back(mk(15, 6, 0, 0, 0, 0, 'h08, 'h00, 5));
    tbl.push_back(mk(15, 7, 0, 0, 0, 0, 'h14, 'h00, 5));
    tbl.push_back(mk(8,  3, 0, 0, 0, 0, 'h02, 'hFF, 5));

    foreach (tbl[n]) begin
      step(tbl[n].in, int'(tbl[n].ra));
      chk($sformatf("tbl%0d_resdt", n), int'(resdt), tbl[n].edt);
      chk($sformatf("tbl%0d_szcy", n), int'(SZCy), tbl[n].esz);
    end

    // G2 = 0x77 and MAR = 0x3C built from G0 = 0xF0
    step(op_in(4, 0, 10, 1), 'h03);
    step(op_in(1, 0, 14, 1), 'h03);
    step(op_in(1, 10, 0, 0), 'h12);
    chk("g2_load", int'(resdt), 'h77);
    step(op_in(4, 0, 10, 1), 'h03);
    step(op_in(1, 0, 10, 1), 'h03);
    step(op_in(1, 4, 0, 0), 'h04);
    chk("mar_load", int'(adrs), 'h3C);

    // read with three wait edges
    v = nop(); v.rd = 1'b1;
    step(v, 'h06);
    chk("rd_busy", int'(busy), 1);
    cnt = int'(mem_req);
    for (int k = 0; k < 3; k++) begin
      step(nop(), 'h06);
      cnt += int'(mem_req);
    end
    v = nop(); v.ack = 1'b1; v.din = 8'hA5;
    step(v, 'h06);
    cnt += int'(mem_req);
    chk("rd_req_cycles", cnt, 4);
    chk("rd_rdr", int'(resdt), 'hA5);
    chk("rd_busy_fall", int'(busy), 0);
    resad = 8'h0D;
    #1;
    chk("rd_flg_e", int'(resdt[4]), 0);

    // write with no ack: timeout
    v = nop(); v.wr = 1'b1;
    step(v, 'h0E);
    chk("wr_state", int'(resdt), 2);
    chk("wr_we", int'(mem_we), 1);
    cnt = 0;
    while (mem_req && cnt < 40) begin
      step(nop(), 'h0D);
      cnt++;
    end
    chk("wr_timeout_edges", cnt, TMO);
    chk("wr_flg_e", int'(resdt[4]), 1);
    resad = 8'h0E;
    #1;
    chk("wr_state_idle", int'(resdt), 0);
    v = nop(); v.fwr = 1'b1;
    step(v, 'h0D);
    chk("fwr_clears_e", int'(resdt[4]), 0);

    // rd and wr together in IDLE
    v = nop(); v.rd = 1'b1; v.wr = 1'b1;
    step(v, 'h0D);
    chk("both_no_txn", int'(busy), 0);
    chk("both_flg_e", int'(resdt[4]), 1);

    // reset during a pending read
    v = nop(); v.rd = 1'b1;
    step(v, 'h12);
    step(nop(), 'h12);
    chk("pre_rst_g2", int'(resdt), 'h77);
    chk("pre_rst_req", int'(mem_req), 1);
    #2 reset_N = 1'b0;
    #1;
    chk("rst_req", int'(mem_req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_g2", int'(resdt), 0);
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset_N = 1'b1;
    v = nop(); v.ack = 1'b1; v.din = 8'h99;
    step(v, 'h06);
    chk("late_ack_busy", int'(busy), 0);
    chk("late_ack_rdr", int'(resdt), 0);

    // randomized run
    for (int n = 0; n < 400; n++) begin
      v.xsrc = 4'($urandom_range(0, 15));
      v.xdst = 4'($urandom_range(0, 15));
      v.op   = 4'($urandom_range(0, 15));
      v.rwr  = 1'($urandom_range(0, 1));
      v.fwr  = 1'($urandom_range(0, 1));
      v.pci  = ($urandom_range(0, 3) == 0);
      v.rd   = ($urandom_range(0, 7) == 0);
      v.wr   = ($urandom_range(0, 7) == 0);
      v.ack  = ($urandom_range(0, 5) == 0);
      v.din  = 8'($urandom_range(0, 255));
      step(v, int'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
